// File: rtl/sobel_config_pkg.sv
// sobel_config_pkg: shared frame/pixel defaults, magnitude width helper and FSM
// state type for the Sobel stream core.
package sobel_config_pkg;

  localparam int DEF_IMG_W     = 256;
  localparam int DEF_IMG_H     = 256;
  localparam int DEF_PIX_W     = 8;
  localparam int DEF_MAG_W     = DEF_PIX_W + 3;
  localparam int DEF_THRESHOLD = 150;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } sobel_state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two pixel rows addressed by column; each accepted pixel
// pushes the column down one row and returns the taps of rows r-1 and r-2.
module sobel_line_buffer
  import sobel_config_pkg::*;
#(
  parameter int  IMG_W = DEF_IMG_W,
  parameter int  PIX_W = DEF_PIX_W,
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [CW-1:0]    col_i,
  input  logic [PIX_W-1:0] pixel_i,
  output logic [PIX_W-1:0] tap1_o,
  output logic [PIX_W-1:0] tap2_o
);

  logic [PIX_W-1:0] row1_q [IMG_W];
  logic [PIX_W-1:0] row2_q [IMG_W];

  assign tap1_o = row1_q[col_i];
  assign tap2_o = row2_q[col_i];

  // No reset: stale contents only ever feed border-masked centres.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      row1_q[col_i] <= pixel_i;
      row2_q[col_i] <= row1_q[col_i];
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel edge detector over one raster frame.
// Build macro SOBEL_MAG_OUT_EN: output saturated magnitude instead of a thresholded mask.
module sobel_stream_core
  import sobel_config_pkg::*;
#(
  parameter int  IMG_W = DEF_IMG_W,
  parameter int  IMG_H = DEF_IMG_H,
  parameter int  PIX_W = DEF_PIX_W,
  localparam int MAG_W = PIX_W + 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [MAG_W-1:0] threshold_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [PIX_W-1:0] s_pixel_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [PIX_W-1:0] m_pixel_o,
  output logic             m_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = MAG_W + 1;

  sobel_state_e     state_q, state_d;
  logic [CW-1:0]    in_col_q, out_col_q;
  logic [RW-1:0]    in_row_q, out_row_q;
  logic [MAG_W-1:0] thr_q;
  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] tap1, tap2;
  logic             done_q;
  logic             out_free, in_fire, in_last, out_load, out_last, border;
  logic [PIX_W-1:0] pix_val, out_value;
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]    ax, ay;
  logic [SW:0]      mag_full;
  logic [MAG_W-1:0] mag;

  // Both streams: a beat transfers on a rising edge where valid && ready; a
  // source holds valid and data stable until then. Input is only taken when
  // the single output register is empty or draining in the same cycle.
  assign out_free  = !m_valid_o || m_ready_i;
  assign s_ready_o = (state_q == ST_STREAM) && out_free;
  assign in_fire   = s_valid_i && s_ready_o;
  assign in_last   = (in_row_q == RW'(IMG_H-1)) && (in_col_q == CW'(IMG_W-1));
  assign out_last  = (out_row_q == RW'(IMG_H-1)) && (out_col_q == CW'(IMG_W-1));
  assign border    = (out_row_q == '0) || (out_row_q == RW'(IMG_H-1)) ||
                     (out_col_q == '0) || (out_col_q == CW'(IMG_W-1));
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign state_o   = state_q;

  sobel_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_line_buffer (
    .clk_i  (clk_i),
    .en_i   (in_fire),
    .col_i  (in_col_q),
    .pixel_i(s_pixel_i),
    .tap1_o (tap1),
    .tap2_o (tap2)
  );

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({{(SW-PIX_W){1'b0}}, p});
  endfunction

  // Window columns c-2, c-1 come from win_q; column c is the live taps + input.
  assign gx = (ext(tap2) + ext(tap1) + ext(tap1) + ext(s_pixel_i))
            - (ext(win_q[0][0]) + ext(win_q[1][0]) + ext(win_q[1][0]) + ext(win_q[2][0]));
  assign gy = (ext(win_q[2][0]) + ext(win_q[2][1]) + ext(win_q[2][1]) + ext(s_pixel_i))
            - (ext(win_q[0][0]) + ext(win_q[0][1]) + ext(win_q[0][1]) + ext(tap2));
  assign ax       = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
  assign ay       = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
  assign mag_full = {1'b0, ax} + {1'b0, ay};
  assign mag      = (|mag_full[SW:MAG_W]) ? '1 : mag_full[MAG_W-1:0];

`ifdef SOBEL_MAG_OUT_EN
  assign pix_val = (|mag[MAG_W-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
`else
  assign pix_val = (mag > thr_q) ? '1 : '0;
`endif
  assign out_value = ((state_q == ST_FLUSH) || border) ? '0 : pix_val;

  always_comb begin
    out_load = 1'b0;
    case (state_q)
      ST_STREAM: out_load = in_fire && ((in_row_q > RW'(1)) ||
                                        ((in_row_q == RW'(1)) && (in_col_q != '0)));
      ST_FLUSH:  out_load = out_free && !(m_valid_o && m_last_o);
      default:   out_load = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_STREAM;
      ST_STREAM: if (in_fire && in_last) state_d = ST_FLUSH;
      ST_FLUSH:  if (m_valid_o && m_ready_i && m_last_o) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      thr_q     <= '0;
      m_valid_o <= 1'b0;
      m_pixel_o <= '0;
      m_last_o  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FLUSH) && (state_d == ST_IDLE);
      if ((state_q == ST_IDLE) && start_i) begin
        thr_q     <= threshold_i;
        in_col_q  <= '0;
        in_row_q  <= '0;
        out_col_q <= '0;
        out_row_q <= '0;
      end
      if (in_fire) begin
        if (in_col_q == CW'(IMG_W-1)) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + RW'(1);
        end else begin
          in_col_q <= in_col_q + CW'(1);
        end
      end
      // Output counters name the centre being emitted and drive border masking.
      if (out_load) begin
        m_valid_o <= 1'b1;
        m_pixel_o <= out_value;
        m_last_o  <= out_last;
        if (out_col_q == CW'(IMG_W-1)) begin
          out_col_q <= '0;
          out_row_q <= out_row_q + RW'(1);
        end else begin
          out_col_q <= out_col_q + CW'(1);
        end
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      win_q[0][0] <= win_q[0][1];
      win_q[0][1] <= tap2;
      win_q[1][0] <= win_q[1][1];
      win_q[1][1] <= tap1;
      win_q[2][0] <= win_q[2][1];
      win_q[2][1] <= s_pixel_i;
    end
  end

endmodule

// File: doc/sobel_stream_core.md
SOBEL_STREAM_CORE -- requirements
Module: sobel_stream_core

Interface
REQ-001 Parameter IMG_W, default 256, pixels per row (>=3).
REQ-002 Parameter IMG_H, default 256, rows per frame (>=3).
REQ-003 Parameter PIX_W, default 8, pixel bit width.
REQ-004 Derived MAG_W = PIX_W+3, magnitude width.
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 start_i  in  1  begin frame; honoured only in IDLE.
REQ-008 threshold_i  in  MAG_W  edge threshold; sampled on accepted start_i.
REQ-009 s_valid_i / s_ready_o / s_pixel_i[PIX_W]  in/out/in  input pixel stream, raster order.
REQ-010 m_valid_o / m_ready_i / m_pixel_o[PIX_W]  out/in/out  output pixel stream, raster order.
REQ-011 m_last_o  out  1  marks final output pixel of frame.
REQ-012 busy_o  out  1  high in any state other than IDLE.
REQ-013 done_o  out  1  one-cycle pulse on FLUSH->IDLE.

Function
REQ-014 FSM states IDLE, STREAM, FLUSH; IDLE->STREAM on start_i; STREAM->FLUSH when pixel IMG_W*IMG_H-1 accepted; FLUSH->IDLE when last output handshakes.
REQ-015 Input transfer when s_valid_i && s_ready_o; s_ready_o = (state==STREAM) && (!m_valid_o || m_ready_i).
REQ-016 Row/column counters track the accepted pixel; column wraps IMG_W-1->0 and increments row.
REQ-017 Two-row line buffer plus 3x3 window registers form neighbourhood of centre (r-1,c-1) for accepted input (r,c).
REQ-018 Gx = (p02+2p12+p22)-(p00+2p10+p20), Gy = (p20+2p21+p22)-(p00+2p01+p02), signed MAG_W+1 bits; mag = |Gx|+|Gy|, saturated to MAG_W bits.
REQ-019 Output for centre (r,c) is all-ones if mag > threshold (strict), else zero.
REQ-020 Border centres (row 0, row IMG_H-1, col 0, col IMG_W-1) output zero regardless of window.
REQ-021 Exactly IMG_W*IMG_H outputs per frame, raster order; output k is emitted one cycle after acceptance of input k+IMG_W+1.
REQ-022 First IMG_W+1 accepted inputs produce no output.
REQ-023 FLUSH emits remaining IMG_W+1 outputs (all border, zero) with no input, one per m_ready_i handshake.
REQ-024 m_valid_o/m_pixel_o held stable while m_valid_o && !m_ready_i.
REQ-025 m_last_o high only with output IMG_W*IMG_H-1.
REQ-026 start_i while busy_o ignored; s_valid_i outside STREAM ignored (s_ready_o low).

Reset
REQ-027 On rst_ni low at clock edge: state=IDLE, counters=0, m_valid_o=0, m_pixel_o=0, m_last_o=0, done_o=0, busy_o=0, s_ready_o=0, stored threshold=0.
REQ-028 Reset mid-frame abandons the frame; line buffer contents not cleared (only read for border-masked or overwritten positions).

Configuration
REQ-029 Macro SOBEL_MAG_OUT_EN defined: m_pixel_o = mag saturated to 2^PIX_W-1 (border still zero), threshold_i ignored.
REQ-030 Macro undefined: binary thresholded output per REQ-019.

Structure
REQ-031 sobel_config_pkg holds IMG_W/IMG_H/PIX_W defaults (256/256/8), MAG_W, default THRESHOLD=150, FSM state enum.
REQ-032 Sub-module sobel_line_buffer: two IMG_W x PIX_W rows, one write/shift per accepted pixel, returns column taps of rows r-1, r-2.

Verification
REQ-033 IMG_W=IMG_H=4, constant-128 frame, threshold 150 -> 16 outputs all 0, m_last_o on 16th, done_o one pulse.
REQ-034 IMG_W=IMG_H=4, left half 0 / right half 255, threshold 150 -> interior centres (1,1),(1,2),(2,1),(2,2) = 255 (mag 1020), borders 0.
REQ-035 Same vertical-edge frame, threshold 1020 -> all 0 (strict compare); threshold 1019 -> interior 255.
REQ-036 m_ready_i toggling 1-of-3 cycles during 8x8 random frame -> output stream identical to golden model, no drops/duplicates, s_ready_o low while stalled.
REQ-037 rst_ni low after 10 inputs, then new start_i with full 4x4 frame -> correct 16 outputs, no residue.
REQ-038 SOBEL_MAG_OUT_EN defined, vertical-edge frame -> interior outputs 255 (saturated 1020), single-step edge 0/10 gives 40.
